// File: rtl/regfile_pkg.sv
// Shared defaults for the register file block.
// Every file that builds or instantiates the register file uses these widths.
package regfile_pkg;

    localparam int RF_DATA_W_DEF = 8;
    localparam int RF_ADDR_W_DEF = 4;

endpackage

// File: rtl/rf_read_port.sv
// One register-file read port: address mux, optional write bypass, and output register.
// The top-level regfile_2w2r instantiates this module twice.
module rf_read_port
    import regfile_pkg::*;
#(
    parameter int          DATA_W   = RF_DATA_W_DEF,
    parameter int          ADDR_W   = RF_ADDR_W_DEF,
    parameter int unsigned DEPTH    = 1 << ADDR_W,
    parameter int          ZERO_REG = 0,
    parameter int          BYPASS   = 1
) (
    input  logic              clk,
    input  logic              Rst,
    input  logic              re,
    input  logic [ADDR_W-1:0] raddr,
    input  logic [DATA_W-1:0] mem [0:DEPTH-1],
    input  logic              we0,
    input  logic [ADDR_W-1:0] waddr0,
    input  logic [DATA_W-1:0] wdata0,
    input  logic              we1,
    input  logic [ADDR_W-1:0] waddr1,
    input  logic [DATA_W-1:0] wdata1,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] value;
    logic [DATA_W-1:0] rdata_d;
    logic [DATA_W-1:0] rdata_q;

    // The bypass checks port 1 first, so it matches the write-conflict priority.
    // The zero register overrides both the array and the bypass.
    always_comb begin
        value = mem[raddr];
        if (BYPASS != 0) begin
            if (we1 && (waddr1 == raddr)) begin
                value = wdata1;
            end else if (we0 && (waddr0 == raddr)) begin
                value = wdata0;
            end
        end
        if ((ZERO_REG != 0) && (raddr == '0)) begin
            value = '0;
        end
        rdata_d = rdata_q;
        if (re) begin
            rdata_d = value;
        end
    end

    always_ff @(posedge clk) begin
        if (Rst) begin
            rdata_q <= '0;
        end else begin
            rdata_q <= rdata_d;
        end
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/regfile_2w2r.sv
// Register file with two write ports, two registered read ports, and a shared read-valid flag.
// Port 1 wins a same-address write conflict. Options: write bypass and a hard-wired zero register.
module regfile_2w2r
    import regfile_pkg::*;
#(
    parameter int DATA_W   = RF_DATA_W_DEF,
    parameter int ADDR_W   = RF_ADDR_W_DEF,
    parameter int ZERO_REG = 0,
    parameter int BYPASS   = 1
) (
    input  logic              clk,
    input  logic              Rst,
    input  logic              we0,
    input  logic [ADDR_W-1:0] waddr0,
    input  logic [DATA_W-1:0] wdata0,
    input  logic              we1,
    input  logic [ADDR_W-1:0] waddr1,
    input  logic [DATA_W-1:0] wdata1,
    input  logic              re,
    input  logic [ADDR_W-1:0] raddr1,
    input  logic [ADDR_W-1:0] raddr2,
    output logic [DATA_W-1:0] rdata1,
    output logic [DATA_W-1:0] rdata2,
    output logic              rvalid
);

    localparam int unsigned DEPTH = 1 << ADDR_W;

    logic [DATA_W-1:0] mem_d [0:DEPTH-1];
    logic [DATA_W-1:0] mem_q [0:DEPTH-1];
    logic              rvalid_d;
    logic              rvalid_q;

    // Port 1 is applied after port 0, so it wins when both ports write the same address.
    always_comb begin
        mem_d = mem_q;
        if (we0) begin
            mem_d[waddr0] = wdata0;
        end
        if (we1) begin
            mem_d[waddr1] = wdata1;
        end
        if (ZERO_REG != 0) begin
            mem_d[0] = '0;
        end
        rvalid_d = re;
    end

    always_ff @(posedge clk) begin
        if (Rst) begin
            mem_q    <= '{default: '0};
            rvalid_q <= 1'b0;
        end else begin
            mem_q    <= mem_d;
            rvalid_q <= rvalid_d;
        end
    end

    rf_read_port #(
        .DATA_W   (DATA_W),
        .ADDR_W   (ADDR_W),
        .DEPTH    (DEPTH),
        .ZERO_REG (ZERO_REG),
        .BYPASS   (BYPASS)
    ) u_rd1 (
        .clk    (clk),
        .Rst    (Rst),
        .re     (re),
        .raddr  (raddr1),
        .mem    (mem_q),
        .we0    (we0),
        .waddr0 (waddr0),
        .wdata0 (wdata0),
        .we1    (we1),
        .waddr1 (waddr1),
        .wdata1 (wdata1),
        .rdata  (rdata1)
    );

    rf_read_port #(
        .DATA_W   (DATA_W),
        .ADDR_W   (ADDR_W),
        .DEPTH    (DEPTH),
        .ZERO_REG (ZERO_REG),
        .BYPASS   (BYPASS)
    ) u_rd2 (
        .clk    (clk),
        .Rst    (Rst),
        .re     (re),
        .raddr  (raddr2),
        .mem    (mem_q),
        .we0    (we0),
        .waddr0 (waddr0),
        .wdata0 (wdata0),
        .we1    (we1),
        .waddr1 (waddr1),
        .wdata1 (wdata1),
        .rdata  (rdata2)
    );

    assign rvalid = rvalid_q;

endmodule

// File: tb/tb_regfile_2w2r.sv
// Bench for regfile_2w2r. It drives two configurations from the same stimulus:
// A uses BYPASS=1 and ZERO_REG=0. B uses BYPASS=0 and ZERO_REG=1.
module tb_regfile_2w2r;

    localparam int DW = 8;
    localparam int AW = 4;

    logic          clk = 1'b0;
    logic          Rst;
    logic          we0, we1, re;
    logic [AW-1:0] waddr0, waddr1, raddr1, raddr2;
    logic [DW-1:0] wdata0, wdata1;
    logic [DW-1:0] a_rdata1, a_rdata2, b_rdata1, b_rdata2;
    logic          a_rvalid, b_rvalid;

    int chk_cnt  = 0;
    int pass_cnt = 0;
    bit check_en = 1'b0;

    always #5 clk = ~clk;

    regfile_2w2r #(.DATA_W(DW), .ADDR_W(AW), .ZERO_REG(0), .BYPASS(1)) dut_a (
        .clk(clk), .Rst(Rst),
        .we0(we0), .waddr0(waddr0), .wdata0(wdata0),
        .we1(we1), .waddr1(waddr1), .wdata1(wdata1),
        .re(re), .raddr1(raddr1), .raddr2(raddr2),
        .rdata1(a_rdata1), .rdata2(a_rdata2), .rvalid(a_rvalid)
    );

    regfile_2w2r #(.DATA_W(DW), .ADDR_W(AW), .ZERO_REG(1), .BYPASS(0)) dut_b (
        .clk(clk), .Rst(Rst),
        .we0(we0), .waddr0(waddr0), .wdata0(wdata0),
        .we1(we1), .waddr1(waddr1), .wdata1(wdata1),
        .re(re), .raddr1(raddr1), .raddr2(raddr2),
        .rdata1(b_rdata1), .rdata2(b_rdata2), .rvalid(b_rvalid)
    );

    // Model state: register contents and the expected output values.
    byte unsigned ma [16];
    byte unsigned mb [16];
    byte unsigned ea1, ea2, eb1, eb2;
    bit           ev;

    function automatic byte unsigned val_a(int a);
        if (we1 && int'(waddr1) == a) return wdata1;
        if (we0 && int'(waddr0) == a) return wdata0;
        return ma[a];
    endfunction

    function automatic byte unsigned val_b(int a);
        if (a == 0) return 8'h00;
        return mb[a];
    endfunction

    initial begin
        foreach (ma[i]) begin
            ma[i] = 0;
            mb[i] = 0;
        end
        ea1 = 0; ea2 = 0; eb1 = 0; eb2 = 0; ev = 0;
    end

    always @(posedge clk) begin
        if (Rst) begin
            foreach (ma[i]) begin
                ma[i] = 0;
                mb[i] = 0;
            end
            ea1 = 0; ea2 = 0; eb1 = 0; eb2 = 0; ev = 0;
        end else begin
            ev = re;
            if (re) begin
                ea1 = val_a(int'(raddr1));
                ea2 = val_a(int'(raddr2));
                eb1 = val_b(int'(raddr1));
                eb2 = val_b(int'(raddr2));
            end
            if (we0) ma[waddr0] = wdata0;
            if (we1) ma[waddr1] = wdata1;
            if (we0 && waddr0 != 0) mb[waddr0] = wdata0;
            if (we1 && waddr1 != 0) mb[waddr1] = wdata1;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        chk_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    endtask

    always @(negedge clk) begin
        if (check_en) begin
            chk("mdl_a_rdata1", 32'(a_rdata1), 32'(ea1));
            chk("mdl_a_rdata2", 32'(a_rdata2), 32'(ea2));
            chk("mdl_a_rvalid", 32'(a_rvalid), 32'(ev));
            chk("mdl_b_rdata1", 32'(b_rdata1), 32'(eb1));
            chk("mdl_b_rdata2", 32'(b_rdata2), 32'(eb2));
            chk("mdl_b_rvalid", 32'(b_rvalid), 32'(ev));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        we0 = 0; we1 = 0; re = 0;
    endtask

    initial begin
        Rst = 1; idle();
        waddr0 = 0; waddr1 = 0; wdata0 = 0; wdata1 = 0; raddr1 = 0; raddr2 = 0;
        tick(); tick();
        Rst = 0;
        check_en = 1'b1;

        // 1: preload 0xA5, then reset with a read in flight, then read back all zeros.
        for (int i = 0; i < 16; i++) begin
            we0 = 1; waddr0 = AW'(i); wdata0 = 8'hA5;
            tick();
        end
        idle();
        re = 1; raddr1 = 4'd1; raddr2 = 4'd2;
        tick();
        chk("pre_a_rdata1", 32'(a_rdata1), 32'hA5);
        chk("pre_b_rdata2", 32'(b_rdata2), 32'hA5);
        Rst = 1;
        tick();
        chk("rst_a_rvalid", 32'(a_rvalid), 32'h0);
        chk("rst_b_rvalid", 32'(b_rvalid), 32'h0);
        chk("rst_a_rdata1", 32'(a_rdata1), 32'h0);
        Rst = 0;
        for (int i = 0; i < 16; i++) begin
            re = 1; raddr1 = AW'(i); raddr2 = AW'(15 - i);
            tick();
            chk("rst_read_a1", 32'(a_rdata1), 32'h0);
            chk("rst_read_a2", 32'(a_rdata2), 32'h0);
            chk("rst_read_b1", 32'(b_rdata1), 32'h0);
        end
        idle();

        // 2: dual write to different addresses, then read both.
        we0 = 1; waddr0 = 4'd3; wdata0 = 8'h11;
        we1 = 1; waddr1 = 4'd7; wdata1 = 8'h22;
        tick();
        idle();
        re = 1; raddr1 = 4'd3; raddr2 = 4'd7;
        tick();
        chk("dual_a_rdata1", 32'(a_rdata1), 32'h11);
        chk("dual_a_rdata2", 32'(a_rdata2), 32'h22);
        chk("dual_a_rvalid", 32'(a_rvalid), 32'h1);
        chk("dual_b_rdata1", 32'(b_rdata1), 32'h11);
        chk("dual_b_rdata2", 32'(b_rdata2), 32'h22);
        idle();

        // 3: write conflict, port 1 wins.
        we0 = 1; waddr0 = 4'd5; wdata0 = 8'h33;
        we1 = 1; waddr1 = 4'd5; wdata1 = 8'h44;
        tick();
        idle();
        re = 1; raddr1 = 4'd5; raddr2 = 4'd5;
        tick();
        chk("conf_a_rdata1", 32'(a_rdata1), 32'h44);
        chk("conf_a_rdata2", 32'(a_rdata2), 32'h44);
        chk("conf_b_rdata1", 32'(b_rdata1), 32'h44);
        idle();

        // 4: same-cycle write and read, with and without bypass.
        we0 = 1; waddr0 = 4'd9; wdata0 = 8'h01;
        tick();
        we0 = 1; waddr0 = 4'd9; wdata0 = 8'h55;
        re = 1; raddr1 = 4'd9; raddr2 = 4'd3;
        tick();
        chk("byp_a_rdata1", 32'(a_rdata1), 32'h55);
        chk("byp_b_rdata1", 32'(b_rdata1), 32'h01);
        we0 = 0;
        tick();
        chk("byp2_a_rdata1", 32'(a_rdata1), 32'h55);
        chk("byp2_b_rdata1", 32'(b_rdata1), 32'h55);

        // Bypass priority when both ports write the same address.
        we0 = 1; waddr0 = 4'd4; wdata0 = 8'h66;
        we1 = 1; waddr1 = 4'd4; wdata1 = 8'h77;
        re = 1; raddr1 = 4'd4; raddr2 = 4'd4;
        tick();
        chk("bprio_a_rdata1", 32'(a_rdata1), 32'h77);
        chk("bprio_b_rdata1", 32'(b_rdata1), 32'h00);
        idle();

        // 5: zero register (only B hard-wires it).
        we1 = 1; waddr1 = 4'd0; wdata1 = 8'hFF;
        re = 1; raddr1 = 4'd7; raddr2 = 4'd0;
        tick();
        chk("zero_b_rdata2", 32'(b_rdata2), 32'h00);
        chk("zero_a_rdata2", 32'(a_rdata2), 32'hFF);
        we1 = 0;
        tick();
        chk("zero2_b_rdata2", 32'(b_rdata2), 32'h00);
        chk("zero2_a_rdata2", 32'(a_rdata2), 32'hFF);
        idle();

        // 6: outputs hold while re=0, then a reset drops the read issued with it.
        re = 1; raddr1 = 4'd7; raddr2 = 4'd7;
        tick();
        chk("hold0_a_rdata1", 32'(a_rdata1), 32'h22);
        re = 0;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("hold_a_rdata1", 32'(a_rdata1), 32'h22);
            chk("hold_b_rdata2", 32'(b_rdata2), 32'h22);
            chk("hold_a_rvalid", 32'(a_rvalid), 32'h0);
        end
        Rst = 1; re = 1;
        tick();
        chk("rrd_a_rdata1", 32'(a_rdata1), 32'h0);
        chk("rrd_a_rdata2", 32'(a_rdata2), 32'h0);
        chk("rrd_b_rdata1", 32'(b_rdata1), 32'h0);
        chk("rrd_a_rvalid", 32'(a_rvalid), 32'h0);
        Rst = 0; idle();
        tick(); tick();

        check_en = 1'b0;
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
